// File: rtl/dof_pkg.sv
// Shared constants for decode_operand_fetch: instruction field positions, opcode classes,
// register count and FSM state encoding.
package dof_pkg;

    localparam int unsigned NumRegs  = 16;
    localparam int unsigned RegAddrW = 4;
    localparam int unsigned OpW      = 4;
    localparam int unsigned InstrW   = 16;

    localparam int unsigned OpMsb   = 15;
    localparam int unsigned OpLsb   = 12;
    localparam int unsigned DestMsb = 11;
    localparam int unsigned DestLsb = 8;
    localparam int unsigned Src1Msb = 7;
    localparam int unsigned Src1Lsb = 4;
    localparam int unsigned Src2Msb = 3;
    localparam int unsigned Src2Lsb = 0;
    localparam int unsigned AddrMsb = 7;
    localparam int unsigned AddrLsb = 0;

    localparam logic [OpW-1:0] OpNop      = 4'd0;
    localparam logic [OpW-1:0] OpHlt      = 4'd1;
    localparam logic [OpW-1:0] OpAluFirst = 4'd2;
    localparam logic [OpW-1:0] OpUnary    = 4'd9;
    localparam logic [OpW-1:0] OpAluLast  = 4'd13;
    localparam logic [OpW-1:0] OpLoad     = 4'd14;
    localparam logic [OpW-1:0] OpStore    = 4'd15;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StStall = 2'd2,
        StHalt  = 2'd3
    } dofState_e;

    function automatic logic isAlu(input logic [OpW-1:0] op);
        return (op >= OpAluFirst) && (op <= OpAluLast);
    endfunction

    function automatic logic writesDest(input logic [OpW-1:0] op);
        return isAlu(op) || (op == OpLoad);
    endfunction

    // STORE reads its data register through the first operand port.
    function automatic logic readsSrc1(input logic [OpW-1:0] op);
        return isAlu(op) || (op == OpStore);
    endfunction

    function automatic logic readsSrc2(input logic [OpW-1:0] op);
        return isAlu(op) && (op != OpUnary);
    endfunction

endpackage

// File: rtl/regfile16x16.sv
// 16-entry register file, two combinational read ports with write-through of the
// same-cycle write, cleared asynchronously by reset.
module regfile16x16
    import dof_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                writeEn,
    input  logic [RegAddrW-1:0] writeAddr,
    input  logic [DATA_W-1:0]   writeData,
    input  logic [RegAddrW-1:0] readAddr1,
    input  logic [RegAddrW-1:0] readAddr2,
    output logic [DATA_W-1:0]   readData1,
    output logic [DATA_W-1:0]   readData2
);

    logic [DATA_W-1:0] mem [NumRegs];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                mem[i] <= '0;
            end
        end else if (writeEn) begin
            mem[writeAddr] <= writeData;
        end
    end

    assign readData1 = (writeEn && (writeAddr == readAddr1)) ? writeData : mem[readAddr1];
    assign readData2 = (writeEn && (writeAddr == readAddr2)) ? writeData : mem[readAddr2];

endmodule

// File: rtl/decode_operand_fetch.sv
// Decode / operand-fetch stage: register file, pending scoreboard, hazard stall and HLT.
// Define FORWARD_EN to bypass hazards on the previous ALU result instead of stalling.
module decode_operand_fetch
    import dof_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [InstrW-1:0]   instr,
    input  logic                instrValid,
    output logic                instrReady,
    output logic [OpW-1:0]      opcode,
    output logic [RegAddrW-1:0] destReg,
    output logic [DATA_W-1:0]   srcVal1,
    output logic [DATA_W-1:0]   srcVal2,
    output logic [MADDR_W-1:0]  memAddr,
    output logic                used1,
    output logic                used2,
    input  logic [RegAddrW-1:0] destRegStore,
    input  logic [DATA_W-1:0]   destVal,
    input  logic                storeNow,
    output logic                storeDone,
    output logic                halted
);

    dofState_e             stateQ, stateD;
    logic [InstrW-1:0]     holdQ, holdD;
    logic [NumRegs-1:0]    pendQ, pendD;
    logic [OpW-1:0]        opcodeQ, opcodeD;
    logic [RegAddrW-1:0]   destRegQ, destRegD;
    logic [DATA_W-1:0]     srcVal1Q, srcVal1D, srcVal2Q, srcVal2D;
    logic [MADDR_W-1:0]    memAddrQ, memAddrD;
    logic                  used1Q, used1D, used2Q, used2D;
    logic                  storeDoneQ;

    logic [InstrW-1:0]     curInstr;
    logic [OpW-1:0]        curOp;
    logic [RegAddrW-1:0]   curDest, curSrc1, curSrc2, rdAddr1;
    logic [DATA_W-1:0]     rdData1, rdData2;
    logic [NumRegs-1:0]    clrMask, setMask, pendEff;
    logic                  haz1, haz2, fwd1, fwd2, candidate, stall, issue;

    regfile16x16 #(
        .DATA_W(DATA_W)
    ) uRegfile (
        .clk      (clk),
        .rst      (rst),
        .writeEn  (storeNow),
        .writeAddr(destRegStore),
        .writeData(destVal),
        .readAddr1(rdAddr1),
        .readAddr2(curSrc2),
        .readData1(rdData1),
        .readData2(rdData2)
    );

    assign curInstr = (stateQ == StStall) ? holdQ : instr;
    assign curOp    = curInstr[OpMsb:OpLsb];
    assign curDest  = curInstr[DestMsb:DestLsb];
    assign curSrc1  = curInstr[Src1Msb:Src1Lsb];
    assign curSrc2  = curInstr[Src2Msb:Src2Lsb];
    assign rdAddr1  = (curOp == OpStore) ? curDest : curSrc1;

    // A write-back landing this cycle resolves the hazard; the read sees it via write-through.
    assign pendEff = pendQ & ~clrMask;
    assign haz1    = readsSrc1(curOp) && pendEff[rdAddr1];
    assign haz2    = readsSrc2(curOp) && pendEff[curSrc2];

`ifdef FORWARD_EN
    // The previous issue is still on the outputs, so an ALU op there is the bypass source.
    assign fwd1 = haz1 && isAlu(opcodeQ) && (destRegQ == rdAddr1);
    assign fwd2 = haz2 && isAlu(opcodeQ) && (destRegQ == curSrc2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign candidate = ((stateQ == StIssue) && instrValid) || (stateQ == StStall);
    assign stall     = candidate && ((haz1 && !fwd1) || (haz2 && !fwd2));
    assign issue     = candidate && !stall;

    always_comb begin
        clrMask = '0;
        setMask = '0;
        clrMask[destRegStore] = storeNow;
        setMask[curDest]      = issue && writesDest(curOp);
        // Set wins over a simultaneous clear of the same register.
        pendD = pendEff | setMask;
    end

    always_comb begin
        stateD   = stateQ;
        holdD    = holdQ;
        opcodeD  = '0;
        destRegD = '0;
        srcVal1D = '0;
        srcVal2D = '0;
        memAddrD = '0;
        used1D   = 1'b0;
        used2D   = 1'b0;

        case (stateQ)
            StIdle:  stateD = StIssue;
            StIssue, StStall: begin
                if (issue) begin
                    stateD = (curOp == OpHlt) ? StHalt : StIssue;
                end else if (stall) begin
                    stateD = StStall;
                    holdD  = curInstr;
                end
            end
            StHalt:  stateD = StHalt;
            default: stateD = StIdle;
        endcase

        if (issue && (curOp != OpNop)) begin
            opcodeD = curOp;
            if (curOp != OpHlt) begin
                destRegD = curDest;
                srcVal1D = (readsSrc1(curOp) && !fwd1) ? rdData1 : '0;
                srcVal2D = (readsSrc2(curOp) && !fwd2) ? rdData2 : '0;
                used1D   = fwd1;
                used2D   = fwd2;
                if ((curOp == OpLoad) || (curOp == OpStore)) begin
                    memAddrD = MADDR_W'(curInstr[AddrMsb:AddrLsb]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ     <= StIdle;
            holdQ      <= '0;
            pendQ      <= '0;
            opcodeQ    <= '0;
            destRegQ   <= '0;
            srcVal1Q   <= '0;
            srcVal2Q   <= '0;
            memAddrQ   <= '0;
            used1Q     <= 1'b0;
            used2Q     <= 1'b0;
            storeDoneQ <= 1'b0;
        end else begin
            stateQ     <= stateD;
            holdQ      <= holdD;
            pendQ      <= pendD;
            opcodeQ    <= opcodeD;
            destRegQ   <= destRegD;
            srcVal1Q   <= srcVal1D;
            srcVal2Q   <= srcVal2D;
            memAddrQ   <= memAddrD;
            used1Q     <= used1D;
            used2Q     <= used2D;
            storeDoneQ <= storeNow;
        end
    end

    assign opcode     = opcodeQ;
    assign destReg    = destRegQ;
    assign srcVal1    = srcVal1Q;
    assign srcVal2    = srcVal2Q;
    assign memAddr    = memAddrQ;
    assign used1      = used1Q;
    assign used2      = used2Q;
    assign storeDone  = storeDoneQ;
    assign halted     = (stateQ == StHalt);
    assign instrReady = (stateQ == StIssue);

endmodule

// File: tb/tb_decode_operand_fetch.sv
// Self-checking bench for decode_operand_fetch: directed scenarios plus a randomized run,
// all checked each cycle against a rule-level reference model.
module tb_decode_operand_fetch;

`ifdef FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr = '0;
    logic        instrValid = 1'b0;
    logic        instrReady;
    logic [3:0]  opcode, destReg;
    logic [15:0] srcVal1, srcVal2;
    logic [7:0]  memAddr;
    logic        used1, used2;
    logic [3:0]  destRegStore = '0;
    logic [15:0] destVal = '0;
    logic        storeNow = 1'b0;
    logic        storeDone, halted;

    always #5 clk = ~clk;

    decode_operand_fetch #(.DATA_W(16), .MADDR_W(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instrValid(instrValid), .instrReady(instrReady),
        .opcode(opcode), .destReg(destReg), .srcVal1(srcVal1), .srcVal2(srcVal2),
        .memAddr(memAddr), .used1(used1), .used2(used2), .destRegStore(destRegStore),
        .destVal(destVal), .storeNow(storeNow), .storeDone(storeDone), .halted(halted)
    );

    logic [52:0] obsVec, expVec;
    assign obsVec = {opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2,
                     storeDone, halted, instrReady};

    int nTests = 0;
    int nFail  = 0;

    // Reference model state
    logic [15:0] mRegs [16];
    bit          mPend [16];
    bit          mHeld, mStarted, mHalted, mPrevAlu;
    logic [3:0]  mPrevDest;
    logic [15:0] mHeldInstr;

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mRegs[i] = '0;
            mPend[i] = 1'b0;
        end
        mHeld = 0; mStarted = 0; mHalted = 0; mPrevAlu = 0;
        mPrevDest = '0; mHeldInstr = '0;
        expVec = '0;
    endtask

    // Predicts the outputs after the coming rising edge from the current inputs.
    task automatic modelStep();
        logic [15:0] ins, eS1, eS2;
        logic [3:0]  op, d, a1, a2, eOp, eDest;
        logic [7:0]  eAddr;
        bit aluOp, rd1, rd2, b1, b2, f1, f2, have, blocked, eU1, eU2, issued;
        have  = mHeld || (mStarted && !mHalted && instrValid);
        ins   = mHeld ? mHeldInstr : instr;
        op    = ins[15:12];
        d     = ins[11:8];
        aluOp = (op >= 2) && (op <= 13);
        rd1   = aluOp || (op == 15);
        rd2   = aluOp && (op != 9);
        a1    = (op == 15) ? d : ins[7:4];
        a2    = ins[3:0];
        b1    = rd1 && mPend[a1] && !(storeNow && destRegStore == a1);
        b2    = rd2 && mPend[a2] && !(storeNow && destRegStore == a2);
        f1    = Fwd && b1 && mPrevAlu && (mPrevDest == a1);
        f2    = Fwd && b2 && mPrevAlu && (mPrevDest == a2);
        blocked = (b1 && !f1) || (b2 && !f2);
        issued  = have && !blocked;
        eOp = '0; eDest = '0; eS1 = '0; eS2 = '0; eAddr = '0; eU1 = 0; eU2 = 0;
        if (issued && op >= 2) begin
            eOp   = op;
            eDest = d;
            eS1   = (rd1 && !f1) ? ((storeNow && destRegStore == a1) ? destVal : mRegs[a1]) : 16'd0;
            eS2   = (rd2 && !f2) ? ((storeNow && destRegStore == a2) ? destVal : mRegs[a2]) : 16'd0;
            eAddr = (op >= 14) ? ins[7:0] : 8'd0;
            eU1   = f1;
            eU2   = f2;
        end else if (issued && op == 1) begin
            eOp = op;
        end
        if (storeNow) begin
            mPend[destRegStore] = 1'b0;
            mRegs[destRegStore] = destVal;
        end
        if (issued && (aluOp || op == 14)) mPend[d] = 1'b1;
        if (issued && op == 1) mHalted = 1;
        mHeld      = have && blocked;
        mHeldInstr = ins;
        mStarted   = 1;
        mPrevAlu   = issued && aluOp;
        mPrevDest  = d;
        expVec = {eOp, eDest, eS1, eS2, eAddr, eU1, eU2, storeNow, mHalted,
                  mStarted && !mHalted && !mHeld};
    endtask

    task automatic cycle();
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [15:0] ins, input bit st,
                         input logic [3:0] sr, input logic [15:0] sv);
        instrValid = v; instr = ins; storeNow = st; destRegStore = sr; destVal = sv;
    endtask

    task automatic test_reset();
        drive(0, '0, 0, '0, '0);
        #2 rst = 1'b1;
        #1 modelReset();
        nTests++;
        if (obsVec !== 53'd0) begin
            nFail++; $display("FAIL reset_async got %h want 0", obsVec);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nTests++;
        if (instrReady !== 1'b0) begin
            nFail++; $display("FAIL reset_idle_ready got %b want 0", instrReady);
        end
        cycle();
        nTests++;
        if (obsVec !== expVec || instrReady !== 1'b1) begin
            nFail++; $display("FAIL reset_first_issue got %h want %h", obsVec, expVec);
        end
    endtask

    task automatic test_preload();
        drive(0, '0, 1, 4'd4, 16'd24);
        cycle();
        nTests++;
        if (storeDone !== 1'b1 || obsVec !== expVec) begin
            nFail++; $display("FAIL preload_done_r4 got %h want %h", obsVec, expVec);
        end
        drive(0, '0, 1, 4'd5, 16'd30);
        cycle();
        nTests++;
        if (storeDone !== 1'b1 || obsVec !== expVec) begin
            nFail++; $display("FAIL preload_done_r5 got %h want %h", obsVec, expVec);
        end
        drive(1, 16'h2C45, 0, '0, '0);
        cycle();
        nTests++;
        if ({opcode, destReg, srcVal1, srcVal2, used1, used2, storeDone} !==
            {4'd2, 4'd12, 16'd24, 16'd30, 2'b00, 1'b0} || obsVec !== expVec) begin
            nFail++; $display("FAIL preload_issue got %h want %h", obsVec, expVec);
        end
        drive(0, '0, 1, 4'd12, 16'h1234);
        cycle();
        nTests++;
        if (obsVec !== expVec) begin
            nFail++; $display("FAIL preload_wb got %h want %h", obsVec, expVec);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 16'h2C45, 0, '0, '0);
        cycle();
        nTests++;
        if (obsVec !== expVec) begin
            nFail++; $display("FAIL raw_first got %h want %h", obsVec, expVec);
        end
        drive(1, 16'h3DC5, 0, '0, '0);
        cycle();
`ifdef FORWARD_EN
        nTests++;
        if ({opcode, destReg, used1, used2, srcVal1, srcVal2} !==
            {4'd3, 4'd13, 2'b10, 16'd0, 16'd30} || obsVec !== expVec) begin
            nFail++; $display("FAIL raw_forward got %h want %h", obsVec, expVec);
        end
        drive(0, '0, 1, 4'd12, 16'h0050);
        cycle();
`else
        drive(0, '0, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            nTests++;
            if (opcode !== 4'd0 || instrReady !== 1'b0 || obsVec !== expVec) begin
                nFail++; $display("FAIL raw_stall[%0d] got %h want %h", i, obsVec, expVec);
            end
            if (i < 2) cycle();
        end
        drive(0, '0, 1, 4'd12, 16'h0050);
        cycle();
        nTests++;
        if ({opcode, used1, used2, srcVal1, srcVal2} !== {4'd3, 2'b00, 16'h0050, 16'd30} ||
            obsVec !== expVec) begin
            nFail++; $display("FAIL raw_release got %h want %h", obsVec, expVec);
        end
`endif
        drive(0, '0, 1, 4'd13, 16'h0060);
        cycle();
        nTests++;
        if (obsVec !== expVec) begin
            nFail++; $display("FAIL raw_cleanup got %h want %h", obsVec, expVec);
        end
    endtask

    task automatic test_load_use();
        drive(1, 16'hE3B4, 0, '0, '0);
        cycle();
        nTests++;
        if ({opcode, destReg, memAddr} !== {4'd14, 4'd3, 8'd180} || obsVec !== expVec) begin
            nFail++; $display("FAIL load_issue got %h want %h", obsVec, expVec);
        end
        drive(1, 16'h2233, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (i == 0) drive(0, '0, 0, '0, '0);
            nTests++;
            if (opcode !== 4'd0 || instrReady !== 1'b0 || obsVec !== expVec) begin
                nFail++; $display("FAIL load_use_stall[%0d] got %h want %h", i, obsVec, expVec);
            end
        end
        drive(0, '0, 1, 4'd3, 16'd45);
        cycle();
        nTests++;
        if ({opcode, destReg, srcVal1, srcVal2} !== {4'd2, 4'd2, 16'd45, 16'd45} ||
            obsVec !== expVec) begin
            nFail++; $display("FAIL load_use_issue got %h want %h", obsVec, expVec);
        end
        drive(0, '0, 1, 4'd2, 16'h0077);
        cycle();
    endtask

    task automatic test_store();
        drive(0, '0, 1, 4'd7, 16'd45);
        cycle();
        drive(1, 16'hF7B4, 0, '0, '0);
        cycle();
        nTests++;
        if ({opcode, memAddr, srcVal1} !== {4'd15, 8'd180, 16'd45} || obsVec !== expVec) begin
            nFail++; $display("FAIL store_issue got %h want %h", obsVec, expVec);
        end
        // A reader of R7 right behind the store must not stall.
        drive(1, 16'h2177, 0, '0, '0);
        cycle();
        nTests++;
        if ({opcode, srcVal1, srcVal2, used1} !== {4'd2, 16'd45, 16'd45, 1'b0} ||
            obsVec !== expVec) begin
            nFail++; $display("FAIL store_no_pending got %h want %h", obsVec, expVec);
        end
        drive(0, '0, 1, 4'd1, 16'h0011);
        cycle();
    endtask

    task automatic test_random();
        logic [3:0] op, r;
        int errs;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            op = 4'($urandom_range(0, 14));
            if (op != 0) op = op + 4'd1;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 16; k++) begin
                    if (mPend[4'(r + 4'(k))]) begin
                        r = 4'(r + 4'(k));
                        break;
                    end
                end
            end
            drive($urandom_range(0, 1) == 1, {op, 12'($urandom)}, $urandom_range(0, 9) < 4,
                  r, 16'($urandom));
            cycle();
            nTests++;
            if (obsVec !== expVec) begin
                nFail++;
                if (errs < 10) $display("FAIL random[%0d] got %h want %h", n, obsVec, expVec);
                errs++;
            end
        end
        drive(0, '0, 0, '0, '0);
    endtask

    task automatic test_reset_stall();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        cycle();
        drive(1, 16'hE900, 0, '0, '0);
        cycle();
        drive(1, 16'h2A99, 0, '0, '0);
        cycle();
        drive(0, '0, 0, '0, '0);
        cycle();
        nTests++;
        if (instrReady !== 1'b0 || opcode !== 4'd0 || obsVec !== expVec) begin
            nFail++; $display("FAIL rst_stall_held got %h want %h", obsVec, expVec);
        end
        #2 rst = 1'b1;
        #1 modelReset();
        nTests++;
        if (obsVec !== 53'd0) begin
            nFail++; $display("FAIL rst_stall_async got %h want 0", obsVec);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        nTests++;
        if (obsVec !== 53'd0) begin
            nFail++; $display("FAIL rst_stall_release got %h want 0", obsVec);
        end
        cycle();
        nTests++;
        if (instrReady !== 1'b1 || opcode !== 4'd0 || obsVec !== expVec) begin
            nFail++; $display("FAIL rst_stall_ready got %h want %h", obsVec, expVec);
        end
        cycle();
        nTests++;
        if (opcode !== 4'd0 || obsVec !== expVec) begin
            nFail++; $display("FAIL rst_stall_dropped got %h want %h", obsVec, expVec);
        end
        // Scoreboard and register file must both be clear again.
        drive(1, 16'h2199, 0, '0, '0);
        cycle();
        nTests++;
        if ({opcode, srcVal1, srcVal2} !== {4'd2, 16'd0, 16'd0} || obsVec !== expVec) begin
            nFail++; $display("FAIL rst_stall_cleared got %h want %h", obsVec, expVec);
        end
    endtask

    task automatic test_halt();
        drive(1, 16'h1000, 0, '0, '0);
        cycle();
        nTests++;
        if ({opcode, halted, instrReady} !== {4'd1, 1'b1, 1'b0} || obsVec !== expVec) begin
            nFail++; $display("FAIL halt_issue got %h want %h", obsVec, expVec);
        end
        drive(1, 16'h2345, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            nTests++;
            if ({opcode, halted, instrReady} !== {4'd0, 1'b1, 1'b0} || obsVec !== expVec) begin
                nFail++; $display("FAIL halt_bubble[%0d] got %h want %h", i, obsVec, expVec);
            end
        end
        drive(0, '0, 1, 4'd6, 16'd99);
        cycle();
        nTests++;
        if ({storeDone, halted, opcode} !== {1'b1, 1'b1, 4'd0} || obsVec !== expVec) begin
            nFail++; $display("FAIL halt_store got %h want %h", obsVec, expVec);
        end
        drive(0, '0, 0, '0, '0);
        cycle();
        nTests++;
        if ({storeDone, halted, instrReady} !== {1'b0, 1'b1, 1'b0} || obsVec !== expVec) begin
            nFail++; $display("FAIL halt_hold got %h want %h", obsVec, expVec);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        modelReset();
        test_reset();
        test_preload();
        test_back_to_back();
        test_load_use();
        test_store();
        test_random();
        test_reset_stall();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/decode_operand_fetch.md
DECODE_OPERAND_FETCH -- requirements
Module: decode_operand_fetch

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, register and operand width; MADDR_W, default 8, memory address width.
REQ-002 clk  input  1  single clock for the block; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 instr  input  16  fetched instruction: [15:12] opcode, [11:8] dest, [7:4] src1, [3:0] src2; [7:0] is memAddr for opcodes 14/15.
REQ-005 instrValid / instrReady  input / output  1 / 1  fetch handshake; an instruction transfers on a clock edge where both are 1.
REQ-006 opcode, destReg  output  4 / 4  issued operation and destination register to the execute stage.
REQ-007 srcVal1, srcVal2  output  16 / 16  issued operand values.
REQ-008 memAddr  output  8  issued load/store address.
REQ-009 used1, used2  output  1 / 1  1 = the operand is to be taken from the execute stage's own previous result (bypass); srcValN is then 0.
REQ-010 destRegStore, destVal, storeNow  input  4 / 16 / 1  register-file write-back from the execute stage.
REQ-011 storeDone  output  1  write-back acknowledge.
REQ-012 halted  output  1  a HLT instruction has been issued.

Function
REQ-013 Opcode classes SHALL be: 0 NOP; 1 HLT; 2-13 ALU (writes dest); 9 unary ALU (src1 only); 14 LOAD (writes dest); 15 STORE (srcVal1 = R[dest field], no write).
REQ-014 All execute-side outputs SHALL be registered; an instruction accepted at edge N SHALL appear on the outputs after edge N, unless it is stalled.
REQ-015 With no instruction to issue, the block SHALL emit a bubble: opcode=0, all other execute-side outputs 0.
REQ-016 The register file SHALL be 16 x DATA_W and SHALL be written on an edge where storeNow=1.
REQ-017 Operand reads in the same cycle as a write to the same register SHALL return destVal (write-through).
REQ-018 storeDone SHALL pulse high for exactly one cycle, on the cycle after each storeNow cycle.
REQ-019 A 16-bit pending scoreboard SHALL track registers awaiting write-back:
- a bit is set when an ALU or LOAD instruction to that register issues;
- a bit is cleared when storeNow writes that register;
- on a simultaneous set and clear of the same bit, set wins.
REQ-020 The FSM SHALL have the states IDLE, ISSUE, STALL and HALT, with these transitions:
- IDLE->ISSUE on the first cycle after reset;
- ISSUE->STALL on an unresolvable hazard;
- STALL->ISSUE when the blocking pending bits clear;
- ISSUE->HALT when HLT issues.
REQ-021 A hazard exists when a source register that is actually read has its pending bit set. Register 0 is not special.
REQ-022 In STALL:
- instrReady SHALL be 0;
- the stalled instruction SHALL be held;
- bubbles SHALL be issued.
It SHALL issue on the edge after the blocking write-back, using the write-through value.
REQ-023 In HALT: instrReady=0, halted=1, bubbles only, until reset.
REQ-024 instrReady SHALL be 1 only in ISSUE with no held instruction.

Reset
REQ-025 Assertion of rst SHALL immediately (asynchronously) produce:
- all outputs 0;
- scoreboard cleared;
- FSM to IDLE;
- any held instruction discarded;
- the register file cleared to 0.
This includes reset asserted mid-stall or in HALT.

Configuration
REQ-026 With FORWARD_EN defined: a hazard solely on the destination of the immediately preceding issued ALU instruction SHALL NOT stall; the block SHALL issue with the matching usedN=1.
REQ-027 With FORWARD_EN defined, hazards on a LOAD destination or on older pending writes SHALL still stall.
REQ-028 Without FORWARD_EN: used1 and used2 SHALL be tied to 0, and every hazard SHALL stall.

Structure
REQ-029 The opcode constants, opcode-class decode, field bit positions, FSM state encoding and the register count SHALL reside in the shared package dof_pkg.
REQ-030 The register file with write-through SHALL be the single sub-module regfile16x16.

Verification
REQ-031 Reset preload: write R4=24 and R5=30 via storeNow, then issue instr 0x2C45. Required: opcode=2, destReg=12, srcVal1=24, srcVal2=30, used=00, and storeDone pulsed once per write.
REQ-032 Back-to-back RAW (FORWARD_EN): 0x2C45 then 0x3DC5. Required second issue: used1=1, srcVal1=0, srcVal2=30, no bubble. Without the macro: the block stalls until storeNow writes R12.
REQ-033 Load-use: 0xE3B4 (LOAD R3, 180) then 0x2233. Required: bubbles and instrReady=0 until storeNow writes R3=45, then issue with srcVal1=srcVal2=45.
REQ-034 Store: R7=45, then 0xF7B4. Required: opcode=15, memAddr=180, srcVal1=45, no pending bit set.
REQ-035 Assert rst for one cycle while STALL is holding an instruction. Required: all outputs 0, the instruction is dropped, and instrReady=1 from the second cycle after release.
REQ-036 Issue HLT 0x1000. Required: halted=1 and instrReady=0 permanently, bubbles only, and a subsequent storeNow still writes and pulses storeDone.
